// File: rtl/shield_ctl_if.sv
// Signal bundle between the shield controller and the game logic around it.
// The controller takes the slave view; the stimulus side takes the master view.
interface shield_ctl_if;
    logic        start_game;
    logic        vblnk;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic        player_hit;
    logic        en;
    logic        was_shield_picked_up;
    logic        shield_active;
    logic [9:0]  shield_remaining;
    logic        player_dmg;
    logic        hit_absorbed;

    modport slave (
        input  start_game,
        input  vblnk,
        input  player_x,
        input  player_y,
        input  player_hit,
        output en,
        output was_shield_picked_up,
        output shield_active,
        output shield_remaining,
        output player_dmg,
        output hit_absorbed
    );

    modport master (
        output start_game,
        output vblnk,
        output player_x,
        output player_y,
        output player_hit,
        input  en,
        input  was_shield_picked_up,
        input  shield_active,
        input  shield_remaining,
        input  player_dmg,
        input  hit_absorbed
    );
endinterface

// File: rtl/shield_ctl.sv
// Shield pickup controller: per-frame spawn / pickup / protection / cooldown
// cycle, plus gating of hazard hits into damage or an absorbed hit.
module shield_ctl #(
    parameter int XPOS            = 300,
    parameter int YPOS            = 200,
    parameter int OFFSET          = 64,
    parameter int PLAYER_W        = 32,
    parameter int PLAYER_H        = 32,
    parameter int SPAWN_FRAMES    = 180,
    parameter int ACTIVE_FRAMES   = 300,
    parameter int COOLDOWN_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    shield_ctl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPAWN,
        VISIBLE,
        ACTIVE,
        COOLDOWN
    } state_t;

    localparam logic [9:0]  SPAWN_LAST    = 10'(SPAWN_FRAMES - 1);
    localparam logic [9:0]  ACTIVE_LAST   = 10'(ACTIVE_FRAMES - 1);
    localparam logic [9:0]  COOLDOWN_LAST = 10'(COOLDOWN_FRAMES - 1);
    localparam logic [9:0]  ACTIVE_LEN    = 10'(ACTIVE_FRAMES);
    localparam logic [11:0] X_LO          = 12'(XPOS);
    localparam logic [11:0] X_HI          = 12'(XPOS + OFFSET);
    localparam logic [11:0] Y_LO          = 12'(YPOS);
    localparam logic [11:0] Y_HI          = 12'(YPOS + OFFSET);
    localparam logic [11:0] PW            = 12'(PLAYER_W);
    localparam logic [11:0] PH            = 12'(PLAYER_H);

    state_t      state_q;
    state_t      state_d;
    logic [9:0]  counter_q;
    logic [9:0]  counter_d;
    logic        vblnk_d;
    logic        tick;
    logic [11:0] px;
    logic [11:0] py;
    logic        overlap;
    logic        absorb;
    logic        damage;

    assign px = {1'b0, bus.player_x};
    assign py = {1'b0, bus.player_y};

    // Player box and shield box intersect; widened to 12 bits so the right/bottom edge sums cannot wrap.
    assign overlap = (px < X_HI) && ((px + PW) > X_LO) &&
                     (py < Y_HI) && ((py + PH) > Y_LO);

    // A hit is only meaningful while a game runs; in ACTIVE it is swallowed by the shield.
    assign absorb = bus.player_hit && bus.start_game && (state_q == ACTIVE);
    assign damage = bus.player_hit && bus.start_game && (state_q != ACTIVE);

    // Frame tick: one-cycle registered pulse on the rising edge of vertical blank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vblnk_d <= bus.vblnk;
            tick    <= bus.vblnk & ~vblnk_d;
        end
    end

    // Next-state and frame-counter logic; dropping start_game overrides everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (bus.start_game) state_d = WAIT_SPAWN;
            WAIT_SPAWN: if (tick && counter_q == SPAWN_LAST) state_d = VISIBLE;
            VISIBLE:    if (tick && overlap) state_d = ACTIVE;
            ACTIVE:     if (bus.player_hit || (tick && counter_q == ACTIVE_LAST)) state_d = COOLDOWN;
            COOLDOWN:   if (tick && counter_q == COOLDOWN_LAST) state_d = WAIT_SPAWN;
            default:    state_d = IDLE;
        endcase
        if (!bus.start_game) state_d = IDLE;

        counter_d = counter_q;
        if (state_d != state_q) counter_d = 10'd0;
        else if (tick)          counter_d = counter_q + 10'd1;
    end

    // State and frame counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            counter_q <= 10'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Outputs decoded from the next state so they move on the same edge as the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.en                   <= 1'b0;
            bus.was_shield_picked_up <= 1'b0;
            bus.shield_active        <= 1'b0;
            bus.shield_remaining     <= 10'd0;
            bus.player_dmg           <= 1'b0;
            bus.hit_absorbed         <= 1'b0;
        end else begin
            bus.en                   <= (state_d == VISIBLE);
            bus.was_shield_picked_up <= (state_d == ACTIVE) || (state_d == COOLDOWN);
            bus.shield_active        <= (state_d == ACTIVE);
            bus.shield_remaining     <= (state_d == ACTIVE) ? (ACTIVE_LEN - counter_d) : 10'd0;
            bus.player_dmg           <= damage;
            bus.hit_absorbed         <= absorb;
        end
    end

endmodule

// File: tb/tb_shield_ctl.sv
// Self-checking bench for shield_ctl with short frame counts.
// Expected output snapshots are queued by the stimulus; a monitor pops one
// whenever the outputs change (or a steady-state check is requested).
module tb_shield_ctl;

    logic clk = 1'b0;
    logic rst;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    shield_ctl_if bus ();

    shield_ctl #(
        .SPAWN_FRAMES    (3),
        .ACTIVE_FRAMES   (4),
        .COOLDOWN_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        probe;
        int          stim;
        logic [14:0] outs;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          stim_id    = 0;
    int          compared   = 0;
    int          mismatched = 0;
    int          probe_req  = 0;
    int          probe_seen = 0;
    logic        mon_en     = 1'b0;
    logic [14:0] prev_outs  = '0;
    logic [14:0] cur_outs;
    logic [14:0] zero_outs  = '0;

    wire [14:0] dut_outs = {bus.en, bus.was_shield_picked_up, bus.shield_active,
                            bus.shield_remaining, bus.player_dmg, bus.hit_absorbed};

    function automatic logic [14:0] mk(input logic e, input logic p, input logic a,
                                       input logic [9:0] r, input logic d, input logic b);
        return {e, p, a, r, d, b};
    endfunction

    // Compare one observed output snapshot against the oldest queued expectation.
    task automatic check_event(input logic is_probe, input logic [14:0] got);
        exp_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_output stim=%0d probe=%0b got=%h required=none", stim_id, is_probe, got);
        end else begin
            e = exp_q.pop_front();
            if (e.probe !== is_probe || e.stim != stim_id || e.outs !== got)
                begin
                    mismatched++;
                    $display("[TB] FAIL %s got outs=%h stim=%0d probe=%0b required outs=%h stim=%0d probe=%0b",
                             e.name, got, stim_id, is_probe, e.outs, e.stim, e.probe);
                end
        end
    endtask

    // Monitor: every output change, or a pending steady-state probe, consumes one expectation.
    always @(negedge clk) begin
        cur_outs = dut_outs;
        if (mon_en) begin
            if (cur_outs !== prev_outs) check_event(1'b0, cur_outs);
            else if (probe_req != probe_seen) begin
                probe_seen++;
                check_event(1'b1, cur_outs);
            end
        end
        prev_outs = cur_outs;
    end

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic new_stim();
        stim_id++;
    endtask

    task automatic expect_out(input string name, input logic [14:0] o);
        exp_q.push_back('{probe: 1'b0, stim: stim_id, outs: o, name: name});
    endtask

    // Steady-state check: outputs must equal o with no change since the last action.
    task automatic check_output(input string name, input logic [14:0] o);
        exp_q.push_back('{probe: 1'b1, stim: stim_id, outs: o, name: name});
        probe_req++;
        settle();
    endtask

    // One vblnk pulse; optional hit lands on the cycle the frame tick reaches the FSM.
    task automatic apply_stimulus(input logic with_hit);
        bus.vblnk = 1'b1;
        @(negedge clk);
        if (with_hit) bus.player_hit = 1'b1;
        @(negedge clk);
        bus.player_hit = 1'b0;
        bus.vblnk      = 1'b0;
        settle();
    endtask

    task automatic apply_hit();
        bus.player_hit = 1'b1;
        @(negedge clk);
        bus.player_hit = 1'b0;
        settle();
    endtask

    // From WAIT_SPAWN (counter 0): three frames until the shield appears.
    task automatic reach_visible();
        new_stim(); apply_stimulus(1'b0);
        new_stim(); apply_stimulus(1'b0);
        new_stim(); expect_out("spawn_visible", mk(1, 0, 0, 10'd0, 0, 0)); apply_stimulus(1'b0);
    endtask

    // From VISIBLE with the player overlapping: one frame picks the shield up.
    task automatic reach_active();
        new_stim(); expect_out("pickup", mk(0, 1, 1, 10'd4, 0, 0)); apply_stimulus(1'b0);
    endtask

    task automatic count_down();
        for (int r = 3; r >= 1; r--) begin
            new_stim(); expect_out("remaining", mk(0, 1, 1, 10'(r), 0, 0)); apply_stimulus(1'b0);
        end
    endtask

    task automatic finish_cooldown();
        new_stim(); apply_stimulus(1'b0);
        new_stim(); expect_out("cooldown_end", zero_outs); apply_stimulus(1'b0);
    endtask

    // Directed scenario sequence.
    initial begin
        rst            = 1'b0;
        bus.start_game = 1'b0;
        bus.vblnk      = 1'b0;
        bus.player_x   = 11'd0;
        bus.player_y   = 11'd0;
        bus.player_hit = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_output("reset_state", zero_outs);

        new_stim(); rst = 1'b1; settle();
        check_output("after_release", zero_outs);

        new_stim(); bus.start_game = 1'b1; settle();
        check_output("wait_spawn_entry", zero_outs);

        new_stim(); apply_stimulus(1'b0);
        new_stim(); apply_stimulus(1'b0);
        check_output("en_low_after_tick2", zero_outs);
        new_stim(); expect_out("spawn_visible", mk(1, 0, 0, 10'd0, 0, 0)); apply_stimulus(1'b0);

        new_stim(); bus.player_x = 11'd364; bus.player_y = 11'd210; settle();
        new_stim(); apply_stimulus(1'b0);
        check_output("no_pickup_x364", mk(1, 0, 0, 10'd0, 0, 0));

        new_stim(); bus.player_x = 11'd310; settle();
        reach_active();
        count_down();
        new_stim(); expect_out("active_expiry", mk(0, 1, 0, 10'd0, 0, 0)); apply_stimulus(1'b0);
        new_stim(); apply_stimulus(1'b0);
        check_output("cooldown_hold", mk(0, 1, 0, 10'd0, 0, 0));
        new_stim(); expect_out("cooldown_end", zero_outs); apply_stimulus(1'b0);

        new_stim();
        expect_out("dmg_rise", mk(0, 0, 0, 10'd0, 1, 0));
        expect_out("dmg_fall", zero_outs);
        apply_hit();

        new_stim(); apply_stimulus(1'b0);
        new_stim(); apply_stimulus(1'b0);
        new_stim(); expect_out("spawn_visible", mk(1, 0, 0, 10'd0, 0, 0)); apply_stimulus(1'b0);
        new_stim();
        expect_out("pickup_with_hit", mk(0, 1, 1, 10'd4, 1, 0));
        expect_out("pickup_dmg_fall", mk(0, 1, 1, 10'd4, 0, 0));
        apply_stimulus(1'b1);

        new_stim();
        expect_out("absorb", mk(0, 1, 0, 10'd0, 0, 1));
        expect_out("absorb_fall", mk(0, 1, 0, 10'd0, 0, 0));
        apply_hit();
        finish_cooldown();

        reach_visible();
        reach_active();
        count_down();
        new_stim();
        expect_out("expiry_hit_absorb", mk(0, 1, 0, 10'd0, 0, 1));
        expect_out("expiry_hit_fall", mk(0, 1, 0, 10'd0, 0, 0));
        apply_stimulus(1'b1);
        finish_cooldown();

        reach_visible();
        reach_active();
        new_stim();
        expect_out("abort", zero_outs);
        bus.start_game = 1'b0;
        bus.player_hit = 1'b1;
        @(negedge clk);
        bus.player_hit = 1'b0;
        settle();
        check_output("abort_no_pulse", zero_outs);

        new_stim(); bus.start_game = 1'b1; settle();
        reach_visible();
        @(posedge clk);
        #2;
        new_stim();
        expect_out("async_reset", zero_outs);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        new_stim();
        bus.player_hit = 1'b1;
        repeat (2) @(negedge clk);
        bus.player_hit = 1'b0;
        settle();
        check_output("no_pulse_in_reset", zero_outs);
        new_stim(); rst = 1'b1; settle();
        check_output("post_reset", zero_outs);

        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s got no output event required outs=%h stim=%0d", e.name, e.outs, e.stim);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
